// File: rtl/nand3_bist_pkg.sv
// Shared types and constants for the NAND3 cell self-test initiator.
// The cell has three inputs, so one sweep covers eight vectors.
package nand3_bist_pkg;

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      SAMPLE,
      DONE
   } state_t;

   localparam int NVEC  = 8;
   localparam int VEC_W = 3;
   localparam int CNT_W = 8;
   localparam int ERR_W = 4;

   // The fault-free NAND3 response: only vector 7 (A=B=C=1) drives Y low.
   localparam logic [NVEC-1:0] GOLDEN_DEFAULT = 8'h7F;

endpackage

// File: rtl/nand3_bist_if.sv
// Bundle between the self-test initiator and its environment.
// The initiator uses the master side; the cell/controller uses the slave side.
interface nand3_bist_if;
   import nand3_bist_pkg::*;

   logic             start;
   logic             y;
   logic             a;
   logic             b;
   logic             c;
   logic             busy;
   logic             done;
   logic [NVEC-1:0]  capture;
   logic [ERR_W-1:0] err_cnt;
   logic [VEC_W-1:0] first_fail;
   logic             fail_valid;

   modport master (
      input  start, y,
      output a, b, c, busy, done, capture, err_cnt, first_fail, fail_valid
   );

   modport slave (
      output start, y,
      input  a, b, c, busy, done, capture, err_cnt, first_fail, fail_valid
   );

endinterface

// File: rtl/bist_resp_capture.sv
// Latches the cell response per vector and tracks mismatches against the
// expected capture word: error count plus the lowest failing vector.
module bist_resp_capture
   import nand3_bist_pkg::*;
#(
   parameter logic [NVEC-1:0] GOLDEN = GOLDEN_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             smp,
   input  logic [VEC_W-1:0] vec,
   input  logic             y,
   output logic [NVEC-1:0]  capture,
   output logic [ERR_W-1:0] err_cnt,
   output logic [VEC_W-1:0] first_fail,
   output logic             fail_valid
);

   logic [NVEC-1:0]  capture_reg;
   logic [ERR_W-1:0] err_cnt_reg;
   logic [VEC_W-1:0] first_fail_reg;
   logic             fail_valid_reg;
   logic [NVEC-1:0]  hit;
   logic             mismatch;

   for (genvar gi = 0; gi < NVEC; gi++) begin : g_hit
      assign hit[gi] = smp && (vec == VEC_W'(gi));
   end

   assign mismatch = smp && (y != GOLDEN[vec]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         capture_reg    <= '0;
         err_cnt_reg    <= '0;
         first_fail_reg <= '0;
         fail_valid_reg <= 1'b0;
      end else if (clr) begin
         capture_reg    <= '0;
         err_cnt_reg    <= '0;
         first_fail_reg <= '0;
         fail_valid_reg <= 1'b0;
      end else begin
         capture_reg <= (capture_reg & ~hit) | (hit & {NVEC{y}});
         if (mismatch) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
            // Vectors are swept in ascending order, so the first miss is the lowest.
            if (!fail_valid_reg) begin
               first_fail_reg <= vec;
               fail_valid_reg <= 1'b1;
            end
         end
      end
   end

   assign capture    = capture_reg;
   assign err_cnt    = err_cnt_reg;
   assign first_fail = first_fail_reg;
   assign fail_valid = fail_valid_reg;

endmodule

// File: rtl/nand3_bist.sv
// NAND3 self-test initiator: sweeps all eight A/B/C vectors, holds each for
// SETTLE cycles, samples Y for one cycle and hands it to the response checker.
module nand3_bist
   import nand3_bist_pkg::*;
#(
   parameter int              SETTLE = 2,
   parameter logic [NVEC-1:0] GOLDEN = GOLDEN_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   nand3_bist_if.master bus
);

   state_t           state_reg, state_next;
   logic [VEC_W-1:0] vec_reg, vec_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             clr;
   logic             smp;
   logic             busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         vec_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         vec_reg   <= vec_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      vec_next   = vec_reg;
      cnt_next   = cnt_reg;
      clr        = 1'b0;
      smp        = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (bus.start) begin
               state_next = APPLY;
               vec_next   = '0;
               cnt_next   = '0;
               clr        = 1'b1;
            end
         end
         APPLY: begin
            if (cnt_reg == CNT_W'(SETTLE - 1)) begin
               state_next = SAMPLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         SAMPLE: begin
            smp = 1'b1;
            if (vec_reg == VEC_W'(NVEC - 1)) begin
               state_next = DONE;
            end else begin
               state_next = APPLY;
               vec_next   = vec_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state_reg == APPLY) || (state_reg == SAMPLE);

   // Pins are parked low outside a sweep; vec holds 7 in DONE otherwise.
   assign {bus.a, bus.b, bus.c} = busy ? vec_reg : '0;
   assign bus.busy = busy;
   assign bus.done = (state_reg == DONE);

   bist_resp_capture #(
      .GOLDEN (GOLDEN)
   ) u_resp_capture (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .smp        (smp),
      .vec        (vec_reg),
      .y          (bus.y),
      .capture    (bus.capture),
      .err_cnt    (bus.err_cnt),
      .first_fail (bus.first_fail),
      .fail_valid (bus.fail_valid)
   );

endmodule

// File: tb/tb_nand3_bist.sv
// Self-checking bench for nand3_bist: a fault-injectable NAND3 cell model,
// a queue of expected sweep results, and a monitor comparing each finished sweep.
module tb_nand3_bist;
   import nand3_bist_pkg::*;

   localparam int          S_MAIN = 2;
   localparam logic [7:0]  GOLD   = 8'h7F;

   typedef struct {
      logic [7:0] cap;
      logic [3:0] err;
      logic [2:0] ff;
      logic       fv;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nand3_bist_if ifc ();
   nand3_bist_if ifc1 ();
   nand3_bist_if ifc255 ();

   nand3_bist #(.SETTLE(S_MAIN), .GOLDEN(GOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.master));
   nand3_bist #(.SETTLE(1),      .GOLDEN(GOLD)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.master));
   nand3_bist #(.SETTLE(255),    .GOLDEN(GOLD)) dut255 (.clk(clk), .rst_n(rst_n), .bus(ifc255.master));

   // Cell model modes: 0 good, 1 stuck-at-1, 2 stuck-at-0, 3 good with per-vector flips.
   int         mode = 0;
   logic [7:0] mask = 8'h00;

   function automatic logic fault_y(input logic [2:0] v, input int m, input logic [7:0] mk);
      logic good;
      good = !(v == 3'd7);
      case (m)
         1:       return 1'b1;
         2:       return 1'b0;
         3:       return good ^ mk[v];
         default: return good;
      endcase
   endfunction

   assign ifc.y    = fault_y({ifc.a, ifc.b, ifc.c}, mode, mask);
   assign ifc1.y   = ~(ifc1.a & ifc1.b & ifc1.c);
   assign ifc255.y = ~(ifc255.a & ifc255.b & ifc255.c);

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t ref_model(input int m, input logic [7:0] mk);
      exp_t       e;
      logic [7:0] g;
      g     = GOLD;
      e.cap = '0;
      e.err = '0;
      e.ff  = '0;
      e.fv  = 1'b0;
      for (int v = 0; v < 8; v++) begin
         e.cap[v] = fault_y(3'(v), m, mk);
         if (e.cap[v] != g[v]) begin
            if (!e.fv) e.ff = 3'(v);
            e.fv = 1'b1;
            e.err++;
         end
      end
      return e;
   endfunction

   exp_t sb_q[$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: checks pin drive every cycle and pops one expectation per DONE rise.
   logic prev_busy = 1'b0;
   logic prev_done = 1'b0;
   int   t_busy = 0;
   int   bidx = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_busy = 1'b0;
         prev_done = 1'b0;
         bidx      = 0;
      end else begin
         if (ifc.busy && !prev_busy) begin
            t_busy = cyc;
            bidx   = 0;
         end
         if (ifc.busy) begin
            check("abc_drive", 32'({ifc.a, ifc.b, ifc.c}), 32'(bidx / (S_MAIN + 1)));
            bidx++;
         end else begin
            check("abc_idle", 32'({ifc.a, ifc.b, ifc.c}), 32'd0);
         end
         if (ifc.done && !prev_done) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 expected no sweep end");
            end else begin
               e = sb_q.pop_front();
               check("capture",    32'(ifc.capture),    32'(e.cap));
               check("err_cnt",    32'(ifc.err_cnt),    32'(e.err));
               check("first_fail", 32'(ifc.first_fail), 32'(e.ff));
               check("fail_valid", 32'(ifc.fail_valid), 32'(e.fv));
               check("latency",    32'(cyc - t_busy),   32'(8 * (S_MAIN + 1)));
               $display("sweep: cap=%02h err=%0d ff=%0d fv=%0d latency=%0d",
                        ifc.capture, ifc.err_cnt, ifc.first_fail, ifc.fail_valid, cyc - t_busy);
            end
         end
         prev_busy = ifc.busy;
         prev_done = ifc.done;
      end
   end

   task automatic wait_done(input int limit);
      int n = 0;
      while (!ifc.done && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!ifc.done) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", limit);
      end
   endtask

   task automatic pulse_start();
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
   endtask

   task automatic run(input int m, input logic [7:0] mk);
      mode = m;
      mask = mk;
      sb_q.push_back(ref_model(m, mk));
      pulse_start();
      wait_done(200);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_abc"},  32'({ifc.a, ifc.b, ifc.c}), 32'd0);
      check({tag, "_busy"}, 32'(ifc.busy),       32'd0);
      check({tag, "_done"}, 32'(ifc.done),       32'd0);
      check({tag, "_cap"},  32'(ifc.capture),    32'd0);
      check({tag, "_err"},  32'(ifc.err_cnt),    32'd0);
      check({tag, "_ff"},   32'(ifc.first_fail), 32'd0);
      check({tag, "_fv"},   32'(ifc.fail_valid), 32'd0);
   endtask

   function automatic logic aux_busy(input int which);
      return (which == 1) ? ifc1.busy : ifc255.busy;
   endfunction

   function automatic logic aux_done(input int which);
      return (which == 1) ? ifc1.done : ifc255.done;
   endfunction

   task automatic run_aux(input int which, input int s);
      int t0;
      int n = 0;
      if (which == 1) ifc1.start = 1'b1; else ifc255.start = 1'b1;
      @(negedge clk);
      ifc1.start   = 1'b0;
      ifc255.start = 1'b0;
      check("aux_busy_rise", 32'(aux_busy(which)), 32'd1);
      t0 = cyc;
      while (!aux_done(which) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("aux_latency", 32'(cyc - t0), 32'(8 * (s + 1)));
      check("aux_capture", 32'((which == 1) ? ifc1.capture : ifc255.capture), 32'(GOLD));
      check("aux_err_cnt", 32'((which == 1) ? ifc1.err_cnt : ifc255.err_cnt), 32'd0);
      $display("aux settle=%0d latency=%0d", s, cyc - t0);
   endtask

   initial begin
      int n;
      ifc.start    = 1'b0;
      ifc1.start   = 1'b0;
      ifc255.start = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("idle");

      run(0, 8'h00);
      run(1, 8'h00);
      run(2, 8'h00);

      // Abort mid-sweep during vector 4 with an asynchronous reset.
      mode = 0;
      pulse_start();
      n = 0;
      while ({ifc.a, ifc.b, ifc.c} != 3'd4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("abort_pre_busy", 32'(ifc.busy), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("abort");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run(0, 8'h00);

      // START pulses during BUSY must not restart the sweep.
      mode = 2;
      sb_q.push_back(ref_model(2, 8'h00));
      pulse_start();
      repeat (5) @(negedge clk);
      pulse_start();
      repeat (7) @(negedge clk);
      pulse_start();
      wait_done(200);
      @(negedge clk);
      check("done_hold_err", 32'(ifc.err_cnt), 32'd7);
      mode = 0;
      sb_q.push_back(ref_model(0, 8'h00));
      pulse_start();
      check("restart_busy", 32'(ifc.busy),       32'd1);
      check("restart_done", 32'(ifc.done),       32'd0);
      check("restart_err",  32'(ifc.err_cnt),    32'd0);
      check("restart_fv",   32'(ifc.fail_valid), 32'd0);
      check("restart_cap",  32'(ifc.capture),    32'd0);
      wait_done(200);
      @(negedge clk);

      // START held high relaunches on the edge after DONE.
      mode = 1;
      sb_q.push_back(ref_model(1, 8'h00));
      sb_q.push_back(ref_model(1, 8'h00));
      ifc.start = 1'b1;
      @(negedge clk);
      wait_done(200);
      @(negedge clk);
      ifc.start = 1'b0;
      check("relaunch_busy", 32'(ifc.busy), 32'd1);
      wait_done(200);
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run(int'($urandom_range(0, 3)), 8'($urandom));
      end

      run_aux(1, 1);
      run_aux(255, 255);

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
